// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state encodings and control-word type for the multicycle MIPS control FSM
package mips_ctrl_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0d;
  localparam logic [5:0] LUI    = 6'h0f;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2b;

  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_ORI   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    I_EXEC   = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
  } state_t;

  // Moore part of the datapath strobes; handshake-gated strobes live in the top.
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_word_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      R_TYPE, ADDI, ORI, LUI, LW, SW, BEQ, BNE, J: op_supported = 1'b1;
      default:                                     op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// rtl/ctrl_word_decode.sv - combinational map from (state, latched opcode) to the Moore control word
module ctrl_word_decode
  import mips_ctrl_pkg::*;
(
  input  state_t       state,
  input  logic [5:0]   op_q,
  output ctrl_word_t   cw
);

  always_comb begin
    cw = '0;
    case (state)
      FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALU_ADD;
      end
      DECODE: begin
        cw.alu_src_b = SRCB_IMM_SH2;
        cw.alu_op    = ALU_ADD;
      end
      MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        cw.iord     = 1'b1;
        cw.mem_read = 1'b1;
      end
      MEM_WB: begin
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      MEM_WR: begin
        cw.iord      = 1'b1;
        cw.mem_write = 1'b1;
      end
      R_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_RTYPE;
      end
      R_WB: begin
        cw.reg_dst    = 1'b1;
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      I_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        case (op_q)
          ORI:     cw.alu_op = ALU_ORI;
          LUI:     cw.alu_op = ALU_LUI;
          default: cw.alu_op = ALU_ADD;
        endcase
      end
      I_WB: begin
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      BRANCH: begin
        cw.alu_src_a  = 1'b1;
        cw.alu_op     = ALU_SUB;
        cw.pc_source  = PCSRC_ALUOUT;
        cw.instr_done = 1'b1;
      end
      JUMP: begin
        cw.pc_source  = PCSRC_JUMP;
        cw.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with memory-ready stalls
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int MEM_WAIT_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic               PCEn,
  output logic               InstrDone,
  output logic               IllegalOp
);

  state_t     state, state_nxt;
  logic [5:0] op_q;
  ctrl_word_t cw;
  logic       rdy;

  assign rdy = MemReady | (MEM_WAIT_EN == 0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) op_q <= OP;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:     state_nxt = FETCH;
      FETCH:    state_nxt = rdy ? DECODE : FETCH;
      DECODE: begin
        case (OP)
          R_TYPE:         state_nxt = R_EXEC;
          ADDI, ORI, LUI: state_nxt = I_EXEC;
          LW, SW:         state_nxt = MEM_ADDR;
          BEQ, BNE:       state_nxt = BRANCH;
          J:              state_nxt = JUMP;
          default:        state_nxt = FETCH;
        endcase
      end
      MEM_ADDR: state_nxt = (op_q == LW) ? MEM_RD : MEM_WR;
      MEM_RD:   state_nxt = rdy ? MEM_WB : MEM_RD;
      MEM_WB:   state_nxt = FETCH;
      MEM_WR:   state_nxt = rdy ? FETCH : MEM_WR;
      R_EXEC:   state_nxt = R_WB;
      R_WB:     state_nxt = FETCH;
      I_EXEC:   state_nxt = I_WB;
      I_WB:     state_nxt = FETCH;
      BRANCH:   state_nxt = FETCH;
      JUMP:     state_nxt = FETCH;
      default:  state_nxt = IDLE;
    endcase
  end

  ctrl_word_decode u_decode (
    .state (state),
    .op_q  (op_q),
    .cw    (cw)
  );

  assign IorD     = cw.iord;
  assign MemRead  = cw.mem_read;
  assign MemWrite = cw.mem_write;
  assign RegDst   = cw.reg_dst;
  assign MemtoReg = cw.mem_to_reg;
  assign RegWrite = cw.reg_write;
  assign ALUSrcA  = cw.alu_src_a;
  assign ALUSrcB  = cw.alu_src_b;
  assign ALUOp    = ALUOP_W'(cw.alu_op);
  assign PCSource = cw.pc_source;

  // Strobes that depend on the handshake, the branch flag or the live opcode.
  always_comb begin
    PCEn      = 1'b0;
    IRWrite   = 1'b0;
    IllegalOp = 1'b0;
    InstrDone = cw.instr_done;
    case (state)
      FETCH: begin
        IRWrite = rdy;
        PCEn    = rdy;
      end
      DECODE: begin
        IllegalOp = ~op_supported(OP);
        InstrDone = ~op_supported(OP);
      end
      MEM_WR:  InstrDone = rdy;
      BRANCH:  PCEn = ((op_q == BEQ) & Zero) | ((op_q == BNE) & ~Zero);
      JUMP:    PCEn = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic       Zero;
  logic       MemReady;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       PCEn, InstrDone, IllegalOp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_W(3), .MEM_WAIT_EN(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .OP        (OP),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .IorD      (IorD),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .PCSource  (PCSource),
    .PCEn      (PCEn),
    .InstrDone (InstrDone),
    .IllegalOp (IllegalOp)
  );

  logic [18:0] obs;
  assign obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSource, PCEn, InstrDone, IllegalOp};

  function automatic logic [18:0] w(input logic iord, mr, mw, irw, rd, m2r, rw, asa,
                                     input logic [1:0] asb, input logic [2:0] aop,
                                     input logic [1:0] pcs, input logic pcen, done, ill);
    w = {iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pcen, done, ill};
  endfunction

  // Expected control words, written out by hand from the state table
  localparam logic [18:0] W_ZERO   = 19'd0;
  logic [18:0] w_fetch, w_fetch_wait, w_decode, w_rexec, w_rwb, w_maddr, w_mrd, w_mwb;
  logic [18:0] w_mwr_wait, w_mwr_done, w_iexec_ori, w_iwb, w_beq_taken, w_bne_not, w_bne_taken, w_illegal;

  task automatic check(input string tag, input logic [18:0] expected);
    vectors++;
    assert (obs === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, expected);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] expected);
    vectors++;
    assert (dut.state === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed_state=%0d expected_state=%0d", tag, dut.state, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    w_fetch      = w(0,1,0,1,0,0,0,0,2'b01,3'b100,2'b00,1,0,0);
    w_fetch_wait = w(0,1,0,0,0,0,0,0,2'b01,3'b100,2'b00,0,0,0);
    w_decode     = w(0,0,0,0,0,0,0,0,2'b11,3'b100,2'b00,0,0,0);
    w_illegal    = w(0,0,0,0,0,0,0,0,2'b11,3'b100,2'b00,0,1,1);
    w_rexec      = w(0,0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0,0);
    w_rwb        = w(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,1,0);
    w_maddr      = w(0,0,0,0,0,0,0,1,2'b10,3'b100,2'b00,0,0,0);
    w_mrd        = w(1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0);
    w_mwb        = w(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,1,0);
    w_mwr_wait   = w(1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0);
    w_mwr_done   = w(1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,1,0);
    w_iexec_ori  = w(0,0,0,0,0,0,0,1,2'b10,3'b101,2'b00,0,0,0);
    w_iwb        = w(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,1,0);
    w_beq_taken  = w(0,0,0,0,0,0,0,1,2'b00,3'b011,2'b01,1,1,0);
    w_bne_not    = w(0,0,0,0,0,0,0,1,2'b00,3'b011,2'b01,0,1,0);
    w_bne_taken  = w(0,0,0,0,0,0,0,1,2'b00,3'b011,2'b01,1,1,0);

    reset = 1'b0; OP = 6'h00; Zero = 1'b0; MemReady = 1'b1;

    // Reset held low for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", W_ZERO);
    end
    check_state("reset_state_idle", 4'd0);
    reset = 1'b1;
    #1;
    check("idle_after_release", W_ZERO);
    check_state("idle_after_release_state", 4'd0);
    tick();
    check_state("fetch_after_idle_state", 4'd1);
    check("fetch_after_idle", w_fetch);

    // R-type: FETCH, DECODE, R_EXEC, R_WB
    OP = 6'h00;
    tick(); check("r_decode", w_decode);
    tick(); check("r_exec", w_rexec);
    tick(); check("r_wb", w_rwb);
    tick(); check("r_back_to_fetch", w_fetch);

    // LW with two wait cycles in MEM_RD
    OP = 6'h23;
    tick(); check("lw_decode", w_decode);
    tick(); check("lw_mem_addr", w_maddr);
    tick(); MemReady = 1'b0; #1; check("lw_mem_rd_wait1", w_mrd);
    tick(); check("lw_mem_rd_wait2", w_mrd);
    tick(); MemReady = 1'b1; #1; check("lw_mem_rd_ready", w_mrd);
    tick(); check("lw_mem_wb", w_mwb);
    tick(); check("lw_back_to_fetch", w_fetch);

    // BEQ taken
    OP = 6'h04; Zero = 1'b1;
    tick(); check("beq_decode", w_decode);
    tick(); check("beq_branch_taken", w_beq_taken);
    tick(); check("beq_back_to_fetch", w_fetch);

    // BNE with Zero=1 is not taken; flipping Zero mid-state takes it combinationally
    OP = 6'h05;
    tick(); check("bne_decode", w_decode);
    tick(); check("bne_branch_not_taken", w_bne_not);
    Zero = 1'b0; #1; check("bne_branch_taken_comb", w_bne_taken);
    tick(); check("bne_back_to_fetch", w_fetch);

    // ORI with OP changed during I_EXEC
    OP = 6'h0d;
    tick(); check("ori_decode", w_decode);
    tick(); OP = 6'h00; #1; check("ori_exec_op_changed", w_iexec_ori);
    tick(); check("ori_i_wb", w_iwb);
    tick(); check("ori_back_to_fetch", w_fetch);

    // Unsupported opcode
    OP = 6'h3f;
    tick(); check("illegal_decode", w_illegal);
    tick(); check("illegal_back_to_fetch", w_fetch);

    // SW stalled in MEM_WR, then reset asserted mid-instruction
    OP = 6'h2b;
    tick(); check("sw_decode", w_decode);
    tick(); check("sw_mem_addr", w_maddr);
    tick(); MemReady = 1'b0; #1; check("sw_mem_wr_wait", w_mwr_wait);
    MemReady = 1'b1; #1; check("sw_mem_wr_ready_comb", w_mwr_done);
    MemReady = 1'b0; #1;
    reset = 1'b0; #1;
    check("sw_reset_async_outputs", W_ZERO);
    check_state("sw_reset_async_state", 4'd0);

    // Restart with memory not ready: FETCH stalls without IRWrite/PCEn
    tick(); reset = 1'b1;
    tick(); check("fetch_stall", w_fetch_wait);
    tick(); check("fetch_stall_hold", w_fetch_wait);
    MemReady = 1'b1; #1; check("fetch_stall_release", w_fetch);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
